// File: rtl/pulse_spacer.sv
// Pulse rate shaper: buffers single-cycle input pulses and re-emits them at least GAP cycles apart.
// Optional macro PULSE_SPACER_STICKY_OVF_EN makes overflow_o sticky (cleared by clr_ovf_i).
module pulse_spacer #(
    parameter int GAP   = 4,
    parameter int CNT_W = 4
) (
    input  logic             aclk,
    input  logic             arst,
    input  logic             pulse_i,
    input  logic             clr_ovf_i,
    output logic             pulse_o,
    output logic [CNT_W-1:0] pending_o,
    output logic             busy_o,
    output logic             overflow_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        WAIT = 2'd2
    } state_t;

    localparam int             GW       = $clog2(GAP);
    localparam logic [GW-1:0]  GAP_LOAD = GW'(GAP - 2);
    localparam logic [CNT_W:0] MAX      = {1'b0, {CNT_W{1'b1}}};

    state_t           state_q, state_d;
    logic [CNT_W-1:0] pend_q, pend_d;
    logic [GW-1:0]    gap_q, gap_d;
    logic             ovf_q, ovf_d;

    logic [CNT_W:0]   total;
    logic [CNT_W:0]   cand;
    logic             slot;
    logic             launch;
    logic             drop;

    always_comb begin
        total  = {1'b0, pend_q} + {{CNT_W{1'b0}}, pulse_i};
        // A launch can happen from IDLE or on the final WAIT cycle, so a
        // continuous backlog is emitted exactly GAP cycles apart.
        slot   = (state_q == IDLE) || ((state_q == WAIT) && (gap_q == '0));
        launch = slot && (total != '0);
        cand   = launch ? (total - (CNT_W+1)'(1)) : total;
        drop   = (cand > MAX);
        pend_d = drop ? MAX[CNT_W-1:0] : cand[CNT_W-1:0];
    end

    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        case (state_q)
            IDLE: begin
                if (launch) state_d = EMIT;
            end
            EMIT: begin
                state_d = WAIT;
                gap_d   = GAP_LOAD;
            end
            WAIT: begin
                if (gap_q == '0) state_d = launch ? EMIT : IDLE;
                else             gap_d   = gap_q - GW'(1);
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef PULSE_SPACER_STICKY_OVF_EN
    // Set has priority over clear so a drop is never hidden.
    always_comb ovf_d = drop | (ovf_q & ~clr_ovf_i);
`else
    logic unused_clr;
    assign unused_clr = clr_ovf_i;
    always_comb ovf_d = drop;
`endif

    always_ff @(posedge aclk or posedge arst) begin
        if (arst) begin
            state_q <= IDLE;
            pend_q  <= '0;
            gap_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            gap_q   <= gap_d;
            ovf_q   <= ovf_d;
        end
    end

    assign pulse_o    = (state_q == EMIT);
    assign pending_o  = pend_q;
    assign busy_o     = (state_q != IDLE) || (pend_q != '0);
    assign overflow_o = ovf_q;

endmodule

// File: tb/tb_pulse_spacer.sv
// Directed bench for pulse_spacer with GAP=4, CNT_W=3 (MAX=7).
module tb_pulse_spacer;

    logic       aclk;
    logic       arst;
    logic       pulse_i;
    logic       clr_ovf_i;
    logic       pulse_o;
    logic [2:0] pending_o;
    logic       busy_o;
    logic       overflow_o;

    int n_chk  = 0;
    int n_fail = 0;

`ifdef PULSE_SPACER_STICKY_OVF_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    pulse_spacer #(.GAP(4), .CNT_W(3)) dut (
        .aclk       (aclk),
        .arst       (arst),
        .pulse_i    (pulse_i),
        .clr_ovf_i  (clr_ovf_i),
        .pulse_o    (pulse_o),
        .pending_o  (pending_o),
        .busy_o     (busy_o),
        .overflow_o (overflow_o)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    typedef struct {
        logic       p;
        logic       c;
        logic       ep;
        logic [2:0] epend;
        logic       eb;
        logic       eo;
    } vec_t;

    vec_t vec [36];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Apply inputs before edge k, sample on the following falling edge.
    task automatic step(input logic p, input logic c);
        pulse_i   = p;
        clr_ovf_i = c;
        @(posedge aclk);
        @(negedge aclk);
    endtask

    task automatic do_reset();
        pulse_i   = 1'b0;
        clr_ovf_i = 1'b0;
        arst      = 1'b1;
        @(negedge aclk);
        @(negedge aclk);
        chk("rst.pulse_o", int'(pulse_o), 0);
        chk("rst.pending_o", int'(pending_o), 0);
        chk("rst.busy_o", int'(busy_o), 0);
        chk("rst.overflow_o", int'(overflow_o), 0);
        arst = 1'b0;
    endtask

    initial begin
        int cnt;
        int last;

        arst      = 1'b1;
        pulse_i   = 1'b0;
        clr_ovf_i = 1'b0;

        // Three-pulse burst at edges 10..12, then a lone pulse at edge 30.
        for (int i = 0; i < 36; i++) vec[i] = '{1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0};
        vec[10] = '{1'b1, 1'b0, 1'b1, 3'd0, 1'b1, 1'b0};
        vec[11] = '{1'b1, 1'b0, 1'b0, 3'd1, 1'b1, 1'b0};
        vec[12] = '{1'b1, 1'b0, 1'b0, 3'd2, 1'b1, 1'b0};
        vec[13] = '{1'b0, 1'b0, 1'b0, 3'd2, 1'b1, 1'b0};
        vec[14] = '{1'b0, 1'b0, 1'b1, 3'd1, 1'b1, 1'b0};
        vec[15] = '{1'b0, 1'b0, 1'b0, 3'd1, 1'b1, 1'b0};
        vec[16] = '{1'b0, 1'b0, 1'b0, 3'd1, 1'b1, 1'b0};
        vec[17] = '{1'b0, 1'b0, 1'b0, 3'd1, 1'b1, 1'b0};
        vec[18] = '{1'b0, 1'b0, 1'b1, 3'd0, 1'b1, 1'b0};
        vec[19] = '{1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0};
        vec[20] = '{1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0};
        vec[21] = '{1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0};
        vec[25] = '{1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0};
        vec[30] = '{1'b1, 1'b0, 1'b1, 3'd0, 1'b1, 1'b0};
        vec[31] = '{1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0};
        vec[32] = '{1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0};
        vec[33] = '{1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0};

        do_reset();
        for (int k = 0; k < 36; k++) begin
            step(vec[k].p, vec[k].c);
            chk($sformatf("vec%0d.pulse_o", k), int'(pulse_o), int'(vec[k].ep));
            chk($sformatf("vec%0d.pending_o", k), int'(pending_o), int'(vec[k].epend));
            chk($sformatf("vec%0d.busy_o", k), int'(busy_o), int'(vec[k].eb));
            chk($sformatf("vec%0d.overflow_o", k), int'(overflow_o), int'(vec[k].eo));
        end

        // Saturation: pulses at edges 0..11, drops at 10 and 11, clear at 30.
        do_reset();
        cnt  = 0;
        last = -1;
        for (int k = 0; k < 60; k++) begin
            step(k <= 11, k == 30);
            if (pulse_o) begin
                if (last >= 0) chk($sformatf("sat.spacing@%0d", k), k - last, 4);
                last = k;
                cnt++;
            end
            if (k == 9) begin
                chk("sat.pend@9", int'(pending_o), 7);
                chk("sat.ovf@9", int'(overflow_o), 0);
            end
            if (k == 10 || k == 11) begin
                chk($sformatf("sat.pend@%0d", k), int'(pending_o), 7);
                chk($sformatf("sat.ovf@%0d", k), int'(overflow_o), 1);
            end
            if (k == 12) begin
                chk("sat.pend@12", int'(pending_o), 6);
                chk("sat.ovf@12", int'(overflow_o), STICKY ? 1 : 0);
            end
            if (k == 29) chk("sat.ovf@29", int'(overflow_o), STICKY ? 1 : 0);
            if (k == 30) chk("sat.ovf@30", int'(overflow_o), 0);
        end
        chk("sat.pulse_count", cnt, 10);
        chk("sat.last_pulse", last, 36);
        chk("sat.busy_end", int'(busy_o), 0);

        // Drop and clear on the same edge: the drop must win.
        do_reset();
        for (int k = 0; k <= 10; k++) step(1'b1, k == 10);
        chk("setclr.ovf@10", int'(overflow_o), 1);
        step(1'b0, 1'b0);
        chk("setclr.ovf@11", int'(overflow_o), STICKY ? 1 : 0);

        // Asynchronous reset while five events are pending.
        do_reset();
        for (int k = 0; k <= 6; k++) step(1'b1, 1'b0);
        chk("arst.pend_before", int'(pending_o), 5);
        chk("arst.busy_before", int'(busy_o), 1);
        pulse_i = 1'b0;
        #2 arst = 1'b1;
        #1;
        chk("arst.pulse_o", int'(pulse_o), 0);
        chk("arst.pending_o", int'(pending_o), 0);
        chk("arst.busy_o", int'(busy_o), 0);
        chk("arst.overflow_o", int'(overflow_o), 0);
        @(negedge aclk);
        @(negedge aclk);
        arst = 1'b0;
        cnt  = 0;
        for (int k = 0; k < 20; k++) begin
            step(1'b0, 1'b0);
            if (pulse_o) cnt++;
        end
        chk("arst.pulses_after", cnt, 0);
        chk("arst.pend_after", int'(pending_o), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
